// File: rtl/tbird_lamp_renderer_if.sv
// Pattern-update channel between the tbird FSM (pattern source) and the
// lamp renderer.
//   pat_we         : one-cycle strobe, captures pat_left/pat_right into staging
//   pat_left       : left-bank lamp bits, bit 0 = innermost lamp
//   pat_right      : right-bank lamp bits, bit 0 = innermost lamp
//   update_pending : renderer holds a staged pattern not yet shown
// Modports: master = pattern source, slave = renderer.
interface tbird_lamp_renderer_if #(
  parameter int LAMPS = 5
);
  logic             pat_we;
  logic [LAMPS-1:0] pat_left;
  logic [LAMPS-1:0] pat_right;
  logic             update_pending;

  modport master (
    output pat_we,
    output pat_left,
    output pat_right,
    input  update_pending
  );

  modport slave (
    input  pat_we,
    input  pat_left,
    input  pat_right,
    output update_pending
  );
endinterface

// File: rtl/tbird_lamp_renderer.sv
// tbird_lamp_renderer
// Renders a left and a right bank of lamp rectangles into 8-bit RGB for the
// VGA output. Lamp patterns are double-buffered: a written pattern sits in
// staging and is copied to the displayed (active) pattern only at the start
// of vertical blank, so a frame never tears.
// Latency from bright/h_count/v_count to RGB is 2 clocks.
//
// Ports:
//   clk        : pixel clock
//   reset      : asynchronous, active-high reset
//   bright     : active-video flag aligned with h_count/v_count
//   h_count    : pixel column
//   v_count    : pixel row
//   pat        : pattern-update channel (slave modport)
//   red_out    : pixel red
//   green_out  : pixel green
//   blue_out   : pixel blue
//
// Optional feature macro: LAMP_OUTLINE_EN
//   When defined, the 1-pixel perimeter of each unlit lamp is drawn grey
//   (8'h40 on all channels). When undefined, unlit lamps are fully black.
module tbird_lamp_renderer #(
  parameter int          COUNTER_BITS = 10,
  parameter int          LAMPS        = 5,
  parameter int          LAMP_W       = 50,
  parameter int          LAMP_H       = 80,
  parameter int          LEFT_X_IN    = 300,
  parameter int          RIGHT_X_IN   = 340,
  parameter int          TOP_Y        = 200,
  parameter int          V_ACTIVE     = 480,
  parameter logic [23:0] LAMP_RGB     = 24'hFF0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bright,
  input  logic [COUNTER_BITS-1:0] h_count,
  input  logic [COUNTER_BITS-1:0] v_count,
  tbird_lamp_renderer_if.slave    pat,
  output logic [7:0]              red_out,
  output logic [7:0]              green_out,
  output logic [7:0]              blue_out
);

  // Two extra bits: one for sign, one for headroom, so a left-bank bound
  // that would go negative compares as negative instead of wrapping.
  localparam int XW = COUNTER_BITS + 2;

  localparam logic signed [XW-1:0] V_TOP  = XW'(TOP_Y);
  localparam logic signed [XW-1:0] V_END  = XW'(TOP_Y + LAMP_H);
  localparam logic signed [XW-1:0] V_LAST = XW'(TOP_Y + LAMP_H - 1);

  // Pattern vectors are {left, right}: left bank in the upper LAMPS bits.
  logic [2*LAMPS-1:0] staging_reg;
  logic [2*LAMPS-1:0] active_reg;
  logic               update_pending_reg;
  logic [2*LAMPS-1:0] pat_in;
  logic               vblank_start;

  assign pat_in       = {pat.pat_left, pat.pat_right};
  assign vblank_start = (v_count == COUNTER_BITS'(V_ACTIVE)) && (h_count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      staging_reg        <= '0;
      active_reg         <= '0;
      update_pending_reg <= 1'b0;
    end else begin
      if (pat.pat_we) begin
        staging_reg <= pat_in;
      end
      if (pat.pat_we && vblank_start) begin
        // Write coinciding with vblank start goes straight to display.
        active_reg         <= pat_in;
        update_pending_reg <= 1'b0;
      end else if (pat.pat_we) begin
        update_pending_reg <= 1'b1;
      end else if (vblank_start && update_pending_reg) begin
        active_reg         <= staging_reg;
        update_pending_reg <= 1'b0;
      end
    end
  end

  assign pat.update_pending = update_pending_reg;

  // ---------------------------------------------------------------------
  // Stage 1: per-lamp hit detection
  // ---------------------------------------------------------------------
  logic signed [XW-1:0] h_ext;
  logic signed [XW-1:0] v_ext;
  logic                 v_hit;
  logic [2*LAMPS-1:0]   hit_next;
  logic [2*LAMPS-1:0]   edge_next;

  assign h_ext = $signed({2'b00, h_count});
  assign v_ext = $signed({2'b00, v_count});
  assign v_hit = (v_ext >= V_TOP) && (v_ext < V_END);

  generate
    for (genvar gi = 0; gi < LAMPS; gi++) begin : g_lamp
      // Left lamp gi grows outward (toward x = 0) from LEFT_X_IN.
      localparam logic signed [XW-1:0] L_LO   = XW'(LEFT_X_IN - (gi + 1) * LAMP_W);
      localparam logic signed [XW-1:0] L_HI   = XW'(LEFT_X_IN - gi * LAMP_W);
      localparam logic signed [XW-1:0] L_LAST = XW'(LEFT_X_IN - gi * LAMP_W - 1);
      // Right lamp gi grows outward (toward larger x) from RIGHT_X_IN.
      localparam logic signed [XW-1:0] R_LO   = XW'(RIGHT_X_IN + gi * LAMP_W);
      localparam logic signed [XW-1:0] R_HI   = XW'(RIGHT_X_IN + (gi + 1) * LAMP_W);
      localparam logic signed [XW-1:0] R_LAST = XW'(RIGHT_X_IN + (gi + 1) * LAMP_W - 1);

      logic left_hit;
      logic right_hit;
      logic v_edge;

      assign left_hit  = v_hit && (h_ext >= L_LO) && (h_ext < L_HI);
      assign right_hit = v_hit && (h_ext >= R_LO) && (h_ext < R_HI);
      assign v_edge    = (v_ext == V_TOP) || (v_ext == V_LAST);

      assign hit_next[LAMPS + gi] = left_hit;
      assign hit_next[gi]         = right_hit;

      assign edge_next[LAMPS + gi] = left_hit  && (v_edge || (h_ext == L_LO) || (h_ext == L_LAST));
      assign edge_next[gi]         = right_hit && (v_edge || (h_ext == R_LO) || (h_ext == R_LAST));
    end
  endgenerate

  logic               s1_bright_reg;
  logic [2*LAMPS-1:0] s1_lit_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_bright_reg <= 1'b0;
      s1_lit_reg    <= '0;
    end else begin
      s1_bright_reg <= bright;
      s1_lit_reg    <= hit_next & active_reg;
    end
  end

`ifdef LAMP_OUTLINE_EN
  // Perimeter pixels of lamps that are currently unlit.
  logic [2*LAMPS-1:0] s1_outline_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_outline_reg <= '0;
    end else begin
      s1_outline_reg <= edge_next & ~active_reg;
    end
  end
`else
  logic unused_edge;
  assign unused_edge = ^edge_next;
`endif

  // ---------------------------------------------------------------------
  // Stage 2: colour selection
  // ---------------------------------------------------------------------
  logic [23:0] rgb_next;
  logic [23:0] rgb_reg;

  always_comb begin
    rgb_next = 24'h000000;
    if (s1_bright_reg) begin
      if (|s1_lit_reg) begin
        rgb_next = LAMP_RGB;
      end
`ifdef LAMP_OUTLINE_EN
      else if (|s1_outline_reg) begin
        rgb_next = 24'h404040;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_reg <= 24'h000000;
    end else begin
      rgb_reg <= rgb_next;
    end
  end

  assign red_out   = rgb_reg[23:16];
  assign green_out = rgb_reg[15:8];
  assign blue_out  = rgb_reg[7:0];

endmodule

// File: doc/tbird_lamp_renderer.md
Name: tbird_lamp_renderer

Overview:
- Pipelined, parametrised successor to the T-bird tail-light bit generator. Renders two banks of lamp rectangles (left and right) from per-lamp on/off vectors into 8-bit RGB for the VGA timing chain.
- Lamp patterns are double-buffered. New patterns are applied only at the start of vertical blank, so a frame never tears mid-scan.
- Sits between the tbird FSM (pattern source) and the VGA output pins, alongside the h/v counters.

Parameters:
- COUNTER_BITS, 10, width of h_count/v_count.
- LAMPS, 5, lamps per side (1..16).
- LAMP_W, 50, lamp width in pixels.
- LAMP_H, 80, lamp height in pixels.
- LEFT_X_IN, 300, x just past the inner edge of the left bank (exclusive bound).
- RIGHT_X_IN, 340, x of the inner edge of the right bank (inclusive).
- TOP_Y, 200, top row of all lamps.
- V_ACTIVE, 480, first v_count value of vertical blank.
- LAMP_RGB, 24'hFF0000, lit-lamp colour {R,G,B}.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- bright  in  1  active-video flag aligned with h_count/v_count
- h_count  in  COUNTER_BITS  pixel column
- v_count  in  COUNTER_BITS  pixel row
- pat_we  in  1  one-cycle strobe; captures pat_left/pat_right into staging
- pat_left  in  LAMPS  left lamps, bit 0 = innermost
- pat_right  in  LAMPS  right lamps, bit 0 = innermost
- update_pending  out  1  staging holds a value not yet applied
- red_out  out  8  pixel red
- green_out  out  8  pixel green
- blue_out  out  8  pixel blue

Behaviour:
- Reset (async, high): staging = 0, active = 0, update_pending = 0, all pipeline registers = 0, RGB outputs = 0.
- Staging write: pat_we = 1 at edge N → staging = {pat_left, pat_right} and update_pending = 1 after edge N. Back-to-back writes: last write wins.
- Vblank-start event: cycle where v_count == V_ACTIVE and h_count == 0.
  - On that edge, if update_pending is set, active = staging and update_pending clears.
  - If pat_we coincides with the event, the new input goes to both staging and active, and update_pending = 0 (bypass).
  - No pending update → active unchanged.
- Geometry (half-open, no overlap between adjacent lamps):
  - Left lamp i: LEFT_X_IN-(i+1)*LAMP_W ≤ h_count < LEFT_X_IN-i*LAMP_W.
  - Right lamp i: RIGHT_X_IN+i*LAMP_W ≤ h_count < RIGHT_X_IN+(i+1)*LAMP_W.
  - Both banks: TOP_Y ≤ v_count < TOP_Y+LAMP_H.
  - Compare at COUNTER_BITS+2 bits, so a left bound going negative never matches (no wrap).
- Pipeline, latency 2 clocks from bright/h_count/v_count to RGB:
  - Stage 1 registers bright plus a per-lamp hit vector ANDed with the active bits.
  - Stage 2 registers RGB: if stage-1 bright = 0 → 0/0/0; else if any lit hit → LAMP_RGB; else → 0/0/0.
- Hazards need no special case: they are simply all bits of both banks set.
- Reset mid-frame: outputs go to 0 immediately. The first valid pixel appears 2 clocks after reset deassert, using active = 0, i.e. black until a pattern is written and a vblank passes.

Optional Feature:
- Macro LAMP_OUTLINE_EN.
- Defined: in stage 2, any pixel on the 1-pixel perimeter of an unlit lamp rectangle outputs 8'h40/8'h40/8'h40 (grey outline); lit lamps are unchanged.
- Undefined: unlit lamps are fully black, with no extra logic.

Test Plan:
- Reset then scan a full frame → every RGB sample is 0; update_pending = 0.
- pat_we with pat_left = 5'b00001 at v_count = 100, then scan:
  - That frame stays black and update_pending = 1.
  - After vblank start, update_pending = 0.
  - Next frame: (h=250..299, v=200..279) = FF/00/00 exactly 2 clocks after the matching counters.
  - h = 249 and h = 300 are black.
- pat_right = 5'b11111, pat_left = 5'b11111 applied → red spans h = 50..299 and h = 340..589 at v = 240; h = 300..339 is black; v = 199 and v = 280 are black.
- pat_we asserted exactly at v_count = 480, h_count = 0 with pat_right = 5'b00010 → active updates on that edge; update_pending stays 0; next frame red only at h = 390..439.
- bright = 0 while counters sit inside a lit lamp → RGB = 0 two clocks later.
- With LAMP_OUTLINE_EN and pattern 0 → (h=250, v=200) gives 40/40/40; (h=275, v=240) gives 0/0/0.
